mix_column_ctrl: RTL and testbench

MIX_COLUMN_CTRL -- requirements
Module: mix_column_ctrl

---
 rtl/mix_column_ctrl.sv | 139 +++++++++++++
 tb/tb_mix_column_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mix_column_ctrl.sv
// AES MixColumns / InvMixColumns controller: a 128-bit state is mixed one column
// per cycle through a single shared GF(2^8) column mixer, with a valid/ready handshake.
module mix_column_ctrl #(
    parameter int INV_EN = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         inv,
    input  logic         bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE,
        MIX,
        DONE
    } state_t;

    state_t       r_fsm;
    state_t       w_fsm_next;
    logic [127:0] r_blk;
    logic [1:0]   r_cnt;
    logic         r_inv;
    logic         r_bypass;
    logic         w_accept;
    logic [31:0]  w_col;
    logic [31:0]  w_mixed;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Shift-and-add multiply; coefficients never exceed 4 bits (0x0e is the largest).
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] c);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 4; i++) begin
            if (c[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Both directions share one circulant structure; only the coefficient row differs.
    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv_sel);
        logic [7:0] a0, a1, a2, a3;
        logic [3:0] c0, c1, c2, c3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        if (inv_sel) begin
            c0 = 4'he; c1 = 4'hb; c2 = 4'hd; c3 = 4'h9;
        end else begin
            c0 = 4'h2; c1 = 4'h3; c2 = 4'h1; c3 = 4'h1;
        end
        return {gmul(a0, c0) ^ gmul(a1, c1) ^ gmul(a2, c2) ^ gmul(a3, c3),
                gmul(a0, c3) ^ gmul(a1, c0) ^ gmul(a2, c1) ^ gmul(a3, c2),
                gmul(a0, c2) ^ gmul(a1, c3) ^ gmul(a2, c0) ^ gmul(a3, c1),
                gmul(a0, c1) ^ gmul(a1, c2) ^ gmul(a2, c3) ^ gmul(a3, c0)};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_fsm <= IDLE;
        else     r_fsm <= w_fsm_next;
    end

    always_comb begin
        w_fsm_next = r_fsm;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        w_accept   = 1'b0;
        case (r_fsm)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept   = 1'b1;
                    w_fsm_next = bypass ? DONE : MIX;
                end
            end
            MIX: begin
                busy = 1'b1;
                if (r_cnt == 2'd3) w_fsm_next = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) w_fsm_next = IDLE;
            end
            default: w_fsm_next = IDLE;
        endcase
    end

    always_comb begin
        case (r_cnt)
            2'd0:    w_col = r_blk[127:96];
            2'd1:    w_col = r_blk[95:64];
            2'd2:    w_col = r_blk[63:32];
            default: w_col = r_blk[31:0];
        endcase
        w_mixed = mix_col(w_col, r_inv);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blk    <= '0;
            r_cnt    <= 2'd0;
            r_inv    <= 1'b0;
            r_bypass <= 1'b0;
        end else if (w_accept) begin
            r_blk    <= in_data;
            r_inv    <= inv && (INV_EN != 0);
            r_bypass <= bypass;
            r_cnt    <= 2'd0;
        end else if (r_fsm == MIX) begin
            if (!r_bypass) begin
                case (r_cnt)
                    2'd0:    r_blk[127:96] <= w_mixed;
                    2'd1:    r_blk[95:64]  <= w_mixed;
                    2'd2:    r_blk[63:32]  <= w_mixed;
                    default: r_blk[31:0]   <= w_mixed;
                endcase
            end
            r_cnt <= r_cnt + 2'd1;
        end
    end

    assign out_data = out_valid ? r_blk : '0;

endmodule

// File: tb/tb_mix_column_ctrl.sv
// Directed bench for mix_column_ctrl: known AES column vectors, bypass, backpressure,
// reset mid-block and back-to-back throughput on an INV_EN=1 and an INV_EN=0 instance.
module tb_mix_column_ctrl;

    localparam logic [127:0] BLK_A = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] BLK_B = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] BLK_D = 128'hd4d4d4d5_d4d4d4d5_d4d4d4d5_d4d4d4d5;
    localparam logic [127:0] BLK_E = 128'hd5d5d7d6_d5d5d7d6_d5d5d7d6_d5d5d7d6;
    localparam logic [127:0] BLK_P = 128'h00112233_44556677_8899aabb_ccddeeff;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [127:0] in_data;
    logic         inv;
    logic         bypass;
    logic         out_ready;
    logic         in_ready,  out_valid,  busy;
    logic [127:0] out_data;
    logic         in_ready0, out_valid0, busy0;
    logic [127:0] out_data0;

    int checks   = 0;
    int failures = 0;

    mix_column_ctrl #(.INV_EN(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .inv(inv), .bypass(bypass), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    mix_column_ctrl #(.INV_EN(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .inv(inv), .bypass(bypass), .out_valid(out_valid0),
        .out_ready(out_ready), .out_data(out_data0), .busy(busy0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; inv = 1'b0; bypass = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 128'h0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: out_valid=%b busy=%b out_data=%h, required 0 0 0", out_valid, busy, out_data);
        end
        checks++;
        if (out_valid0 !== 1'b0 || busy0 !== 1'b0 || out_data0 !== 128'h0) begin
            failures++;
            $display("[TB] FAIL reset_outputs_inv0: out_valid=%b busy=%b out_data=%h, required 0 0 0", out_valid0, busy0, out_data0);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || in_ready0 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_in_ready: got %b/%b, required 1/1", in_ready, in_ready0);
        end
    endtask

    // First acceptance lands on the first edge after reset release.
    task automatic test_forward();
        in_valid = 1'b1; in_data = BLK_A; inv = 1'b0; bypass = 1'b0; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL fwd_accept: busy=%b in_ready=%b out_valid=%b, required 1 0 0", busy, in_ready, out_valid);
        end
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL fwd_early_valid: cycle %0d out_valid=%b, required 0", k, out_valid);
            end
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== BLK_B) begin
            failures++;
            $display("[TB] FAIL fwd_result: out_valid=%b out_data=%h, required 1 %h", out_valid, out_data, BLK_B);
        end
        checks++;
        if (out_valid0 !== 1'b1 || out_data0 !== BLK_B) begin
            failures++;
            $display("[TB] FAIL fwd_result_inv0: out_valid=%b out_data=%h, required 1 %h", out_valid0, out_data0, BLK_B);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL fwd_release: out_valid=%b in_ready=%b busy=%b, required 0 1 0", out_valid, in_ready, busy);
        end
    endtask

    task automatic test_inverse();
        in_valid = 1'b1; in_data = BLK_B; inv = 1'b1; bypass = 1'b0; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== BLK_A) begin
            failures++;
            $display("[TB] FAIL inv_result: out_valid=%b out_data=%h, required 1 %h", out_valid, out_data, BLK_A);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        // With INV_EN=0 the inv request must be ignored.
        in_valid = 1'b1; in_data = BLK_A; inv = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        checks++;
        if (out_valid0 !== 1'b1 || out_data0 !== BLK_B) begin
            failures++;
            $display("[TB] FAIL inv_disabled: out_valid=%b out_data=%h, required 1 %h", out_valid0, out_data0, BLK_B);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        inv = 1'b0;
    endtask

    task automatic test_bypass();
        in_valid = 1'b1; in_data = BLK_P; inv = 1'b1; bypass = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; bypass = 1'b0; inv = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== BLK_P || busy !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bypass_result: out_valid=%b busy=%b in_ready=%b out_data=%h, required 1 1 0 %h",
                     out_valid, busy, in_ready, out_data, BLK_P);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL bypass_busy_len: busy=%b out_valid=%b in_ready=%b, required 0 0 1", busy, out_valid, in_ready);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int badStable;
        badStable = 0;
        in_valid = 1'b1; in_data = BLK_A; inv = 1'b0; bypass = 1'b0; out_ready = 1'b0;
        tick();
        in_data = BLK_D; inv = 1'b1; bypass = 1'b1;
        repeat (4) tick();
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== BLK_B) begin
                failures++;
                badStable++;
                $display("[TB] FAIL bp_hold: cycle %0d out_valid=%b in_ready=%b out_data=%h, required 1 0 %h",
                         k, out_valid, in_ready, out_data, BLK_B);
            end
            tick();
        end
        in_valid = 1'b0; inv = 1'b0; bypass = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bp_release: out_valid=%b in_ready=%b busy=%b, required 0 1 0", out_valid, in_ready, busy);
        end
        if (badStable != 0) $display("[TB] backpressure hold errors: %0d", badStable);
    endtask

    task automatic test_reset_mid();
        int seenValid;
        seenValid = 0;
        in_valid = 1'b1; in_data = BLK_A; inv = 1'b0; bypass = 1'b0; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 128'h0 || in_ready !== 1'b0 + 1'b1) begin
            failures++;
            $display("[TB] FAIL rst_mid_async: out_valid=%b busy=%b in_ready=%b out_data=%h, required 0 0 1 0",
                     out_valid, busy, in_ready, out_data);
        end
        tick();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (out_valid === 1'b1) seenValid++;
        end
        checks++;
        if (seenValid != 0) begin
            failures++;
            $display("[TB] FAIL rst_mid_ghost: out_valid seen %0d cycles, required 0", seenValid);
        end
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = BLK_D;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== BLK_E) begin
            failures++;
            $display("[TB] FAIL rst_next_block: out_valid=%b out_data=%h, required 1 %h", out_valid, out_data, BLK_E);
        end
        // Reset while the result is held must also clear the outputs at once.
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 128'h0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rst_done_async: out_valid=%b busy=%b out_data=%h, required 0 0 0", out_valid, busy, out_data);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [127:0] blkIn [3];
        logic [127:0] blkExp[3];
        logic         blkInv[3];
        logic         rdy, ov;
        logic [127:0] od;
        int           acc, res, lastAcc;
        blkIn[0] = BLK_A; blkInv[0] = 1'b0; blkExp[0] = BLK_B;
        blkIn[1] = BLK_B; blkInv[1] = 1'b1; blkExp[1] = BLK_A;
        blkIn[2] = BLK_D; blkInv[2] = 1'b0; blkExp[2] = BLK_E;
        acc = 0; res = 0; lastAcc = -1;
        in_valid = 1'b1; in_data = blkIn[0]; inv = blkInv[0]; bypass = 1'b0; out_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && res < 3; cyc++) begin
            rdy = in_ready;
            ov  = out_valid;
            od  = out_data;
            tick();
            if (rdy && in_valid) begin
                if (acc > 0) begin
                    checks++;
                    if (cyc - lastAcc != 6) begin
                        failures++;
                        $display("[TB] FAIL b2b_period: block %0d gap %0d cycles, required 6", acc, cyc - lastAcc);
                    end
                end
                lastAcc = cyc;
                acc++;
                if (acc < 3) begin
                    in_data = blkIn[acc];
                    inv     = blkInv[acc];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (ov && out_ready) begin
                checks++;
                if (od !== blkExp[res]) begin
                    failures++;
                    $display("[TB] FAIL b2b_result: block %0d out_data=%h, required %h", res, od, blkExp[res]);
                end
                res++;
            end
        end
        checks++;
        if (res != 3) begin
            failures++;
            $display("[TB] FAIL b2b_timeout: results %0d, required 3", res);
        end
        in_valid = 1'b0; out_ready = 1'b0; inv = 1'b0;
    endtask

    initial begin
        test_reset();
        test_forward();
        test_inverse();
        test_bypass();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
